// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, store size encodings and the queued store entry type
package mips_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int BE_W       = DATA_WIDTH / 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be;
  } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - combinational SB/SH/SW lane packer and byte-enable generator
// MISALIGN_EXC_EN: flag misaligned halves/words and the reserved size instead of ignoring them
module store_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]            size_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [BE_W-1:0]       be_o,
  output logic                  misaligned_o
);

  // Word and reserved sizes fall through to the full-lane default.
  always_comb begin
    wdata_o      = data_i;
    be_o         = 4'b1111;
    misaligned_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        wdata_o = {4{data_i[7:0]}};
        be_o    = 4'b0001 << addr_lo_i;
      end
      SIZE_HALF: begin
        wdata_o = {2{data_i[15:0]}};
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
`ifdef MISALIGN_EXC_EN
    case (size_i)
      SIZE_HALF: misaligned_o = addr_lo_i[0];
      SIZE_WORD: misaligned_o = |addr_lo_i;
      SIZE_RSVD: misaligned_o = 1'b1;
      default:   misaligned_o = 1'b0;
    endcase
`endif
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - packs MEM-stage stores into lanes and drains them in order to data memory
// Misaligned-store rejection is controlled by MISALIGN_EXC_EN inside store_lane_align.
module store_unit
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [1:0]            st_size,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [BE_W-1:0]       mem_be,
  output logic                  misalign_exc,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  store_entry_t           fifo_q [DEPTH];
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
  logic                   exc_q, exc_d;
  logic                   full, accept, push, pop;
  logic [DATA_WIDTH-1:0]  pk_wdata;
  logic [BE_W-1:0]        pk_be;
  logic                   pk_mis;
  store_entry_t           head;

  store_lane_align u_align (
    .size_i       (st_size),
    .addr_lo_i    (st_addr[1:0]),
    .data_i       (st_data),
    .wdata_o      (pk_wdata),
    .be_o         (pk_be),
    .misaligned_o (pk_mis)
  );

  assign full     = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                    (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign st_ready = !full;
  assign accept   = st_valid && st_ready;
  // A rejected store still completes its handshake; it just never enters the queue.
  assign push     = accept && !pk_mis;
  assign pop      = !empty && mem_ack;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    exc_d    = accept && pk_mis;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      exc_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      exc_q    <= exc_d;
      if (push) begin
        fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{addr:  {st_addr[ADDR_WIDTH-1:2], 2'b00},
                                         wdata: pk_wdata,
                                         be:    pk_be};
      end
    end
  end

  // Storage is cleared on reset, so the head view reads all-zero until the first push.
  assign head         = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign mem_req      = !empty;
  assign mem_addr     = head.addr;
  assign mem_wdata    = head.wdata;
  assign mem_be       = head.be;
  assign misalign_exc = exc_q;

endmodule
